dft_uart_rx_word: RTL and testbench



---
 rtl/dft_uart_pkg.sv | 17 +
 rtl/dft_uart_rx_timer.sv | 37 +++
 rtl/dft_uart_rx_word.sv | 177 +++++++++++++++++
 tb/tb_dft_uart_rx_word.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_uart_pkg.sv
// Shared definitions for the DFT UART word serialiser/deserialiser pair.
// State encoding, byte width and the default inter-byte timeout.
package dft_uart_pkg;

  localparam int unsigned BYTE_W = 8;

  // 0.5 s at 50 MHz
  localparam int unsigned TIMEOUT_CYCLES_DEF = 25_000_000;

  typedef enum logic [1:0] {
    StIdle,
    StAssemble,
    StCheck,
    StHold
  } uart_rx_state_e;

endpackage

// File: rtl/dft_uart_rx_timer.sv
// Saturating inter-byte timeout counter; expired_o is high once the count
// reaches Limit-1 and stays there until cleared.
module dft_uart_rx_timer #(
  parameter int unsigned Limit = 16,
  parameter int unsigned Width = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [Width-1:0] Last = Width'(Limit - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dft_uart_rx_word.sv
// Reassembles UART bytes MSB-first into BIT_WIDTH-bit words on a valid/ready port.
// Optional trailing XOR checksum byte when DFT_UART_RX_CSUM_EN is defined.
module dft_uart_rx_word
  import dft_uart_pkg::*;
#(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BYTE_W-1:0]    rx_dat,
  input  logic                 rx_valid,
  output logic [BIT_WIDTH-1:0] word_o,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 err_overrun,
  output logic                 err_timeout,
  output logic                 err_csum
);

  localparam int unsigned BYTES     = BIT_WIDTH / BYTE_W;
  localparam int unsigned TMR_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CntW      = $clog2(BYTES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BYTES - 1);

  // Without the checksum the newest byte comes straight from rx_dat, so only
  // the older BYTES-1 bytes need storing.
`ifdef DFT_UART_RX_CSUM_EN
  localparam int unsigned ShregW = BIT_WIDTH;
`else
  localparam int unsigned ShregW = BIT_WIDTH - BYTE_W;
`endif

  uart_rx_state_e       state_q, state_d;
  logic [ShregW-1:0]    shreg_q, shreg_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] word_q, word_d;
  logic                 word_valid_q, word_valid_d;
  logic                 err_overrun_q, err_overrun_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [BIT_WIDTH-1:0] shifted;
  logic                 take;
  logic                 in_window;
  logic                 tmr_expired;

`ifdef DFT_UART_RX_CSUM_EN
  logic [BYTE_W-1:0]    csum_q, csum_d;
  logic                 err_csum_q, err_csum_d;

  assign shifted  = {shreg_q[BIT_WIDTH-BYTE_W-1:0], rx_dat};
  assign err_csum = err_csum_q;
`else
  assign shifted  = {shreg_q, rx_dat};
  assign err_csum = 1'b0;
`endif

  assign in_window = (state_q == StAssemble) || (state_q == StCheck);

  dft_uart_rx_timer #(
    .Limit (TIMEOUT_CYCLES),
    .Width (TMR_WIDTH)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (rx_valid || !in_window),
    .en_i      (in_window),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    word_valid_d  = word_valid_q;
    err_overrun_d = 1'b0;
    err_timeout_d = 1'b0;
    take          = 1'b0;
`ifdef DFT_UART_RX_CSUM_EN
    csum_d        = csum_q;
    err_csum_d    = 1'b0;
`endif

    unique case (state_q)
      StIdle: take = rx_valid;
      StAssemble, StCheck: begin
        // A byte on the expiry cycle wins over the timeout.
        if (rx_valid) begin
          take = 1'b1;
        end else if (tmr_expired) begin
          err_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = StIdle;
        end
      end
      StHold: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          state_d      = StIdle;
          take         = rx_valid;
        end else if (rx_valid) begin
          err_overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
`ifdef DFT_UART_RX_CSUM_EN
      if (state_q == StCheck) begin
        cnt_d = '0;
        if (rx_dat == csum_q) begin
          word_d       = shreg_q;
          word_valid_d = 1'b1;
          state_d      = StHold;
        end else begin
          err_csum_d = 1'b1;
          state_d    = StIdle;
        end
      end else
`endif
      begin
        shreg_d = shifted[ShregW-1:0];
`ifdef DFT_UART_RX_CSUM_EN
        csum_d  = (cnt_q == '0) ? rx_dat : (csum_q ^ rx_dat);
`endif
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
`ifdef DFT_UART_RX_CSUM_EN
          state_d = StCheck;
`else
          word_d       = shifted;
          word_valid_d = 1'b1;
          state_d      = StHold;
`endif
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = StAssemble;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      cnt_q         <= '0;
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef DFT_UART_RX_CSUM_EN
      csum_q        <= '0;
      err_csum_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      word_valid_q  <= word_valid_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
`ifdef DFT_UART_RX_CSUM_EN
      csum_q        <= csum_d;
      err_csum_q    <= err_csum_d;
`endif
    end
  end

  assign word_o      = word_q;
  assign word_valid  = word_valid_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_dft_uart_rx_word.sv
// Bench for dft_uart_rx_word: directed scenarios plus random traffic, all
// checked each cycle against a byte-queue reference model.
module tb_dft_uart_rx_word;

  localparam int unsigned W     = 32;
  localparam int unsigned BYTES = W / 8;
  localparam int unsigned TMO   = 16;
`ifdef DFT_UART_RX_CSUM_EN
  localparam int unsigned NBYTES = BYTES + 1;
`else
  localparam int unsigned NBYTES = BYTES;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_dat = '0;
  logic         rx_valid = 1'b0;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_o;
  logic         word_valid;
  logic         err_overrun;
  logic         err_timeout;
  logic         err_csum;

  int n_checks = 0;
  int n_fail   = 0;

  dft_uart_rx_word #(
    .BIT_WIDTH      (W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_dat      (rx_dat),
    .rx_valid    (rx_valid),
    .word_o      (word_o),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout),
    .err_csum    (err_csum)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the word in progress, idle cycles since the last
  // byte, and the presented word.
  byte unsigned m_q[$];
  int           m_idle;
  bit           m_pend;
  logic [W-1:0] m_word;
  bit           m_ovr, m_tmo, m_csum;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_idle = 0;
    m_pend = 1'b0;
    m_word = '0;
    m_ovr  = 1'b0;
    m_tmo  = 1'b0;
    m_csum = 1'b0;
  endfunction

  function automatic void model_complete();
    logic [W-1:0] w;
    byte unsigned x;
    w = '0;
    x = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      w = {w[W-9:0], m_q[i]};
      x = x ^ m_q[i];
    end
`ifdef DFT_UART_RX_CSUM_EN
    if (m_q[BYTES] == x) begin
      m_word = w;
      m_pend = 1'b1;
    end else begin
      m_csum = 1'b1;
    end
`else
    m_word = w;
    m_pend = 1'b1;
`endif
    m_q.delete();
  endfunction

  function automatic void model_step(input bit v, input byte unsigned d, input bit r);
    bit hs;
    hs     = m_pend && r;
    m_ovr  = 1'b0;
    m_tmo  = 1'b0;
    m_csum = 1'b0;
    if (m_pend && !hs) begin
      m_ovr = v;
    end else begin
      if (hs) m_pend = 1'b0;
      if (v) begin
        m_q.push_back(d);
        m_idle = 0;
        if (m_q.size() == NBYTES) model_complete();
      end else if (m_q.size() != 0) begin
        m_idle++;
        if (m_idle >= TMO) begin
          m_tmo = 1'b1;
          m_q.delete();
          m_idle = 0;
        end
      end
    end
  endfunction

  task automatic cycle(input bit v, input byte unsigned d, input bit r);
    rx_valid   = v;
    rx_dat     = d;
    word_ready = r;
    @(posedge clk);
    #1;
    model_step(v, d, r);
    check("word_valid", W'(word_valid), W'(m_pend));
    check("word_o", word_o, m_word);
    check("err_overrun", W'(err_overrun), W'(m_ovr));
    check("err_timeout", W'(err_timeout), W'(m_tmo));
    check("err_csum", W'(err_csum), W'(m_csum));
    rx_valid   = 1'b0;
    word_ready = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    byte unsigned b;
    byte unsigned x;
    x = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      if (i > 0) repeat (gap) cycle(1'b0, 8'h00, 1'b0);
      b = w[W-1-8*i -: 8];
      x = x ^ b;
      cycle(1'b1, b, 1'b0);
    end
`ifdef DFT_UART_RX_CSUM_EN
    cycle(1'b1, x, 1'b0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_o"}, word_o, '0);
    check({tag, "_valid"}, W'(word_valid), '0);
    check({tag, "_ovr"}, W'(err_overrun), '0);
    check({tag, "_tmo"}, W'(err_timeout), '0);
    check({tag, "_csum"}, W'(err_csum), '0);
  endtask

  initial begin
    int tmo_pulses;
    bit saw_valid;
    bit v;
    bit r;

    model_reset();
    #1 rst = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // DEADBEEF with 3-cycle spacing, held, then handshake.
    send_word(32'hDEADBEEF, 3);
    check("t1_valid", W'(word_valid), W'(1));
    check("t1_word", word_o, 32'hDEADBEEF);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    check("t1_held", word_o, 32'hDEADBEEF);
    cycle(1'b0, 8'h00, 1'b1);
    check("t1_after_hs", W'(word_valid), W'(0));

    // Partial word times out.
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0);
    tmo_pulses = 0;
    saw_valid  = 1'b0;
    repeat (TMO + 2) begin
      cycle(1'b0, 8'h00, 1'b0);
      tmo_pulses += int'(err_timeout);
      saw_valid  |= word_valid;
    end
    check("t2_tmo_pulses", W'(tmo_pulses), W'(1));
    check("t2_no_valid", W'(saw_valid), W'(0));
    send_word(32'h11223344, 0);
    check("t2_word", word_o, 32'h11223344);
    cycle(1'b0, 8'h00, 1'b1);

    // Overrun while held, then byte on the handshake cycle starts the next word.
    send_word(32'h01020304, 1);
    cycle(1'b1, 8'h55, 1'b0);
    check("t3_overrun", W'(err_overrun), W'(1));
    check("t3_word_kept", word_o, 32'h01020304);
    check("t3_valid_kept", W'(word_valid), W'(1));
    cycle(1'b1, 8'h99, 1'b1);
    check("t3_hs_low", W'(word_valid), W'(0));
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0);
    cycle(1'b1, 8'hCC, 1'b0);
`ifdef DFT_UART_RX_CSUM_EN
    cycle(1'b1, 8'h99 ^ 8'hAA ^ 8'hBB ^ 8'hCC, 1'b0);
`endif
    check("t3_next_word", word_o, 32'h99AABBCC);
    cycle(1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-word.
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h34, 1'b0);
    #3 rst = 1'b0;
    #1 check_reset_outputs("t4_async");
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    send_word(32'hCAFEBABE, 2);
    check("t4_word", word_o, 32'hCAFEBABE);
    cycle(1'b0, 8'h00, 1'b1);

`ifdef DFT_UART_RX_CSUM_EN
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h34, 1'b0);
    cycle(1'b1, 8'h56, 1'b0);
    cycle(1'b1, 8'h78, 1'b0);
    cycle(1'b1, 8'h08, 1'b0);
    check("t5_csum_ok", word_o, 32'h12345678);
    check("t5_csum_valid", W'(word_valid), W'(1));
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h34, 1'b0);
    cycle(1'b1, 8'h56, 1'b0);
    cycle(1'b1, 8'h78, 1'b0);
    cycle(1'b1, 8'h09, 1'b0);
    check("t5_csum_err", W'(err_csum), W'(1));
    check("t5_csum_novalid", W'(word_valid), W'(0));
`endif

    // Random traffic with occasional long gaps to exercise the timeout.
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 99) < 35);
      r = ($urandom_range(0, 99) < 30);
      cycle(v, 8'($urandom), r);
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(TMO - 3, TMO + 3)) cycle(1'b0, 8'h00, ($urandom_range(0, 3) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
